// File: rtl/as5600_i2c_target.sv
// as5600_i2c_target
// Minimal I2C target that mimics the AS5600 angle encoder register map.
// Answers reads of STATUS (0x0B), RAW ANGLE (0x0C/0x0D) and ANGLE (0x0E/0x0F)
// from a 12-bit angle snapshot taken when a read is addressed, so both bytes
// of one read are coherent. Write bytes after the pointer are ACKed and dropped.
//
// Ports:
//   clock      in   main clock (single domain)
//   reset      in   synchronous active-high reset
//   scl        in   I2C clock from the initiator (asynchronous)
//   sda_in     in   sampled I2C data line (asynchronous)
//   sda_oe     out  open-drain pull-down enable (1 = drive SDA low)
//   angle      in   12-bit raw angle from the encoder model
//   reg_ptr    out  current register pointer
//   busy       out  high whenever the FSM is not idle
//   xfer_done  out  one-cycle pulse on a STOP ending an addressed transaction
module as5600_i2c_target #(
  parameter logic [6:0] DEV_ADDR   = 7'h36,
  parameter logic [7:0] STATUS_VAL = 8'h20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [11:0] angle,
  output logic [7:0]  reg_ptr,
  output logic        busy,
  output logic        xfer_done
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_REG       = 4'd3,
    S_REG_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_TX        = 4'd7,
    S_TX_ACK    = 4'd8,
    S_WAIT_STOP = 4'd9
  } state_t;

  // Synchronizer stages plus one delayed copy for edge detection
  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;

  state_t      r_state;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_tx;
  logic [11:0] r_hold;
  logic        r_rw;
  logic        r_addressed;
  logic        r_ack_ok;
  logic        r_sda_oe;
  logic [7:0]  r_reg_ptr;
  logic        r_xfer_done;

  logic       w_start;
  logic       w_stop;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_byte_done;
  logic [7:0] w_tx_byte;

  // Register read map, evaluated against the angle snapshot
  function automatic logic [7:0] f_read_byte(input logic [7:0] addr, input logic [11:0] hold);
    case (addr)
      8'h0B:        f_read_byte = STATUS_VAL;
      8'h0C, 8'h0E: f_read_byte = {4'h0, hold[11:8]};
      8'h0D, 8'h0F: f_read_byte = hold[7:0];
      default:      f_read_byte = 8'h00;
    endcase
  endfunction

  // Bus conditions from the synchronized lines, one cycle apart
  assign w_start     = r_scl_s2 &  r_sda_d & ~r_sda_s2;
  assign w_stop      = r_scl_s2 & ~r_sda_d &  r_sda_s2;
  assign w_scl_rise  =  r_scl_s2 & ~r_scl_d;
  assign w_scl_fall  = ~r_scl_s2 &  r_scl_d;
  assign w_byte_done = (r_bit_cnt == 4'd8);
  assign w_tx_byte   = f_read_byte(r_reg_ptr, r_hold);

  // 2-flop synchronizers; reset to the idle-bus level so no false START/STOP
  always_ff @(posedge clock) begin
    if (reset) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  // Protocol FSM; START/STOP are checked before any SCL data edge
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'h00;
      r_tx        <= 8'h00;
      r_hold      <= 12'h000;
      r_rw        <= 1'b0;
      r_addressed <= 1'b0;
      r_ack_ok    <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_reg_ptr   <= 8'h00;
      r_xfer_done <= 1'b0;
    end else begin
      r_xfer_done <= 1'b0;
      if (w_start) begin
        r_state     <= S_ADDR;
        r_bit_cnt   <= 4'd0;
        r_sda_oe    <= 1'b0;
        r_addressed <= 1'b0;
      end else if (w_stop) begin
        r_state     <= S_IDLE;
        r_bit_cnt   <= 4'd0;
        r_sda_oe    <= 1'b0;
        r_xfer_done <= r_addressed;
        r_addressed <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_REG, S_WDATA: begin
            if (w_scl_rise && !w_byte_done) begin
              r_shift   <= {r_shift[6:0], r_sda_s2};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && w_byte_done) begin
              r_bit_cnt <= 4'd0;
              if (r_state == S_ADDR) begin
                if (r_shift[7:1] == DEV_ADDR) begin
                  r_state     <= S_ADDR_ACK;
                  r_sda_oe    <= 1'b1;
                  r_rw        <= r_shift[0];
                  r_addressed <= 1'b1;
                  if (r_shift[0]) r_hold <= angle;
                end else begin
                  r_state <= S_WAIT_STOP;
                end
              end else if (r_state == S_REG) begin
                r_reg_ptr <= r_shift;
                r_state   <= S_REG_ACK;
                r_sda_oe  <= 1'b1;
              end else begin
                r_state  <= S_WDATA_ACK;
                r_sda_oe <= 1'b1;
              end
            end
          end

          // ACK runs from the falling edge after bit 8 to the one after bit 9
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              if (r_rw) begin
                r_state  <= S_TX;
                r_tx     <= w_tx_byte;
                r_sda_oe <= ~w_tx_byte[7];
              end else begin
                r_state  <= S_REG;
                r_sda_oe <= 1'b0;
              end
            end
          end

          S_REG_ACK, S_WDATA_ACK: begin
            if (w_scl_fall) begin
              r_state   <= S_WDATA;
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= 4'd0;
            end
          end

          // Bit 7 is already on the line at entry; shift the next bit out on each fall
          S_TX: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (w_byte_done) begin
                r_state   <= S_TX_ACK;
                r_sda_oe  <= 1'b0;
                r_reg_ptr <= r_reg_ptr + 8'd1;
                r_bit_cnt <= 4'd0;
              end else if (r_bit_cnt != 4'd0) begin
                r_tx     <= {r_tx[6:0], 1'b0};
                r_sda_oe <= ~r_tx[6];
              end
            end
          end

          // Pointer was already advanced, so the next byte comes from the new address
          S_TX_ACK: begin
            if (w_scl_rise) begin
              r_ack_ok  <= ~r_sda_s2;
              r_bit_cnt <= 4'd1;
            end else if (w_scl_fall && (r_bit_cnt == 4'd1)) begin
              r_bit_cnt <= 4'd0;
              if (r_ack_ok) begin
                r_state  <= S_TX;
                r_tx     <= w_tx_byte;
                r_sda_oe <= ~w_tx_byte[7];
              end else begin
                r_state  <= S_WAIT_STOP;
                r_sda_oe <= 1'b0;
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign reg_ptr   = r_reg_ptr;
  assign xfer_done = r_xfer_done;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_as5600_i2c_target.sv
// Scoreboard bench for as5600_i2c_target: stimulus pushes expected bytes,
// ACK bits, xfer_done pulses and status values; a monitor compares them to
// what the bus master and the pulse watcher actually observe.
module tb_as5600_i2c_target;

  logic        clock = 1'b0;
  logic        reset;
  logic        scl;
  logic        sda_in;
  logic        sda_oe;
  logic [11:0] angle;
  logic [7:0]  reg_ptr;
  logic        busy;
  logic        xfer_done;

  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  localparam int unsigned Q = 8;

  string       exp_tag[$];
  int unsigned exp_val[$];
  string       obs_tag[$];
  int unsigned obs_val[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned oe_cnt   = 0;

  assign scl    = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  always #5 clock = ~clock;

  as5600_i2c_target #(.DEV_ADDR(7'h36), .STATUS_VAL(8'h20)) dut (
    .clock     (clock),
    .reset     (reset),
    .scl       (scl),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .angle     (angle),
    .reg_ptr   (reg_ptr),
    .busy      (busy),
    .xfer_done (xfer_done)
  );

  task automatic wq();
    repeat (Q) @(negedge clock);
  endtask

  task automatic expect_item(input string t, input int unsigned v);
    exp_tag.push_back(t);
    exp_val.push_back(v);
  endtask

  task automatic observe(input string t, input int unsigned v);
    obs_tag.push_back(t);
    obs_val.push_back(v);
  endtask

  task automatic check(input string t, input int unsigned e, input int unsigned a);
    expect_item(t, e);
    observe(t, a);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wq();
    scl_m = 1'b1; wq(); wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    b = sda_in; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic write_byte(input string t, input logic [7:0] d, input logic exp_ack);
    logic a;
    expect_item(t, 32'(exp_ack));
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    observe(t, 32'(a));
  endtask

  task automatic read_byte(input string t, input logic [7:0] e, input logic ack);
    logic [7:0] d;
    logic       b;
    expect_item(t, 32'(e));
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack);
    observe(t, 32'(d));
  endtask

  // Pulse watcher and SDA-drive counter
  always @(negedge clock) begin
    if (xfer_done) observe("xfer_done", 1);
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  // Scoreboard monitor
  initial begin
    string       t;
    string       et;
    int unsigned v;
    int unsigned ev;
    forever begin
      @(negedge clock);
      while (obs_tag.size() > 0) begin
        t = obs_tag.pop_front();
        v = obs_val.pop_front();
        n_checks++;
        if (exp_tag.size() == 0) begin
          $display("FAIL %s: got 0x%0h, nothing expected", t, v);
        end else begin
          et = exp_tag.pop_front();
          ev = exp_val.pop_front();
          if (et == t && ev == v) n_pass++;
          else $display("FAIL %s: got %s=0x%0h, expected %s=0x%0h", et, t, v, et, ev);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned oe_before;
    logic        b;
    reset = 1'b1;
    angle = 12'h000;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("rst_sda_oe", 0, 32'(sda_oe));
    check("rst_busy", 0, 32'(busy));
    check("rst_reg_ptr", 0, 32'(reg_ptr));
    check("rst_xfer_done", 0, 32'(xfer_done));

    // Pointer write, repeated START, two-byte read of RAW ANGLE
    angle = 12'hABC;
    i2c_start();
    write_byte("t1_addr_w", 8'h6C, 1'b0);
    check("t1_busy", 1, 32'(busy));
    write_byte("t1_ptr", 8'h0C, 1'b0);
    check("t1_ptr_loaded", 32'h0C, 32'(reg_ptr));
    i2c_start();
    write_byte("t1_addr_r", 8'h6D, 1'b0);
    read_byte("t1_rd_hi", 8'h0A, 1'b0);
    read_byte("t1_rd_lo", 8'hBC, 1'b1);
    expect_item("xfer_done", 1);
    i2c_stop();
    check("t1_reg_ptr", 32'h0E, 32'(reg_ptr));
    check("t1_busy_idle", 0, 32'(busy));

    // Angle changes between the bytes; the snapshot must hold
    angle = 12'h123;
    i2c_start();
    write_byte("t2_addr_w", 8'h6C, 1'b0);
    write_byte("t2_ptr", 8'h0C, 1'b0);
    i2c_start();
    write_byte("t2_addr_r", 8'h6D, 1'b0);
    read_byte("t2_rd_hi", 8'h01, 1'b0);
    angle = 12'h456;
    read_byte("t2_rd_lo", 8'h23, 1'b1);
    expect_item("xfer_done", 1);
    i2c_stop();

    // Foreign address: no ACK, no drive, no pulse
    oe_before = oe_cnt;
    i2c_start();
    write_byte("t3_bad_addr_nack", 8'h70, 1'b1);
    check("t3_wait_stop_busy", 1, 32'(busy));
    i2c_stop();
    check("t3_no_sda_drive", 0, oe_cnt - oe_before);
    check("t3_busy_idle", 0, 32'(busy));

    // Following transfer works: STATUS read
    i2c_start();
    write_byte("t4_addr_w", 8'h6C, 1'b0);
    write_byte("t4_ptr", 8'h0B, 1'b0);
    i2c_start();
    write_byte("t4_addr_r", 8'h6D, 1'b0);
    read_byte("t4_status", 8'h20, 1'b1);
    expect_item("xfer_done", 1);
    i2c_stop();
    check("t4_reg_ptr", 32'h0C, 32'(reg_ptr));

    // Extra write bytes are ACKed and do not touch the pointer
    i2c_start();
    write_byte("t5_addr_w", 8'h6C, 1'b0);
    write_byte("t5_ptr", 8'h0B, 1'b0);
    write_byte("t5_wd0", 8'h11, 1'b0);
    write_byte("t5_wd1", 8'h22, 1'b0);
    write_byte("t5_wd2", 8'h33, 1'b0);
    expect_item("xfer_done", 1);
    i2c_stop();
    check("t5_reg_ptr", 32'h0B, 32'(reg_ptr));

    // Pointer wrap from 0xFF
    angle = 12'hFFF;
    i2c_start();
    write_byte("t6_addr_w", 8'h6C, 1'b0);
    write_byte("t6_ptr", 8'hFF, 1'b0);
    i2c_start();
    write_byte("t6_addr_r", 8'h6D, 1'b0);
    read_byte("t6_rd_ff", 8'h00, 1'b0);
    read_byte("t6_rd_00", 8'h00, 1'b1);
    expect_item("xfer_done", 1);
    i2c_stop();
    check("t6_reg_ptr_wrap", 32'h01, 32'(reg_ptr));

    // ANGLE register pair and the first unmapped address after it
    angle = 12'h5A7;
    i2c_start();
    write_byte("t7_addr_w", 8'h6C, 1'b0);
    write_byte("t7_ptr", 8'h0E, 1'b0);
    i2c_start();
    write_byte("t7_addr_r", 8'h6D, 1'b0);
    read_byte("t7_rd_0e", 8'h05, 1'b0);
    read_byte("t7_rd_0f", 8'hA7, 1'b0);
    read_byte("t7_rd_10", 8'h00, 1'b1);
    expect_item("xfer_done", 1);
    i2c_stop();
    check("t7_reg_ptr", 32'h11, 32'(reg_ptr));

    // Reset while the target is pulling SDA low mid-read
    angle = 12'h0F0;
    i2c_start();
    write_byte("t8_addr_w", 8'h6C, 1'b0);
    write_byte("t8_ptr", 8'h0C, 1'b0);
    i2c_start();
    write_byte("t8_addr_r", 8'h6D, 1'b0);
    for (int i = 0; i < 3; i++) read_bit(b);
    check("t8_sda_oe_before", 1, 32'(sda_oe));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t8_sda_oe_after", 0, 32'(sda_oe));
    check("t8_busy_after", 0, 32'(busy));
    check("t8_reg_ptr_after", 0, 32'(reg_ptr));
    i2c_stop();
    check("t8_busy_end", 0, 32'(busy));

    repeat (50) @(negedge clock);
    while (exp_tag.size() > 0) begin
      n_checks++;
      $display("FAIL %s: no output observed, expected 0x%0h", exp_tag.pop_front(), exp_val.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/as5600_i2c_target.md
AS5600_I2C_TARGET -- requirements
Module: as5600_i2c_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h36, the 7-bit I2C address the block responds to.
REQ-002 SHALL have parameter STATUS_VAL, default 8'h20, the value returned for register 0x0B (magnet detected).
REQ-003 SHALL have port clock  input  1  main clock; single clock domain.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port scl  input  1  I2C clock from the initiator, asynchronous.
REQ-006 SHALL have port sda_in  input  1  sampled I2C data line, asynchronous.
REQ-007 SHALL have port sda_oe  output  1  open-drain pull-down enable; 1 drives SDA low, 0 releases SDA.
REQ-008 SHALL have port angle  input  12  current raw angle presented by the encoder model.
REQ-009 SHALL have port reg_ptr  output  8  current register pointer.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port xfer_done  output  1  one-cycle pulse on STOP that ends an addressed transaction.

Function
REQ-012 SHALL pass scl and sda_in through 2-flop synchronizers; all edge detection SHALL use the synchronized values, 1 cycle apart.
REQ-013 SHALL detect START as sync-SDA falling while sync-SCL high, and STOP as sync-SDA rising while sync-SCL high.
REQ-014 SHALL sample data bits on sync-SCL rising edges, MSB first, and SHALL change sda_oe only on sync-SCL falling edges.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, TX, TX_ACK, WAIT_STOP.
REQ-016 START in any state SHALL go to ADDR with bit counter cleared and sda_oe=0 (repeated START supported).
REQ-017 STOP in any state SHALL go to IDLE with sda_oe=0; reg_ptr SHALL be retained.
REQ-018 ADDR: after 8 bits, if bits[7:1]==DEV_ADDR go to ADDR_ACK, otherwise go to WAIT_STOP without ACK.
REQ-019 ADDR_ACK: drive sda_oe=1 from the falling edge after bit 8 until the falling edge after bit 9; next state TX if R/W=1, REG if R/W=0.
REQ-020 On entering ADDR_ACK with R/W=1, SHALL snapshot angle into a 12-bit hold register so high and low bytes of one read are coherent.
REQ-021 REG: the 8 received bits SHALL load reg_ptr; ACK in REG_ACK; then WDATA.
REQ-022 WDATA/WDATA_ACK: further write bytes SHALL be ACKed and discarded (read-only device); reg_ptr unchanged.
REQ-023 TX read map: 0x0B->STATUS_VAL; 0x0C and 0x0E->{4'h0,hold[11:8]}; 0x0D and 0x0F->hold[7:0]; all other addresses->8'h00.
REQ-024 TX: the byte SHALL be loaded at the ADDR_ACK/TX_ACK exit falling edge; each bit drives sda_oe = ~bit; sda_oe=0 during the 9th (ACK) clock.
REQ-025 After each transmitted byte reg_ptr SHALL increment by 1, wrapping 8'hFF->8'h00.
REQ-026 TX_ACK: initiator ACK (SDA low on rising edge) -> TX with next byte; NACK -> WAIT_STOP, SDA released.
REQ-027 WAIT_STOP SHALL ignore everything except START and STOP.
REQ-028 xfer_done SHALL pulse only when STOP occurs after an address match since the last START or STOP.
REQ-029 START and STOP detected in the same cycle as a data edge SHALL take priority over the data edge.

Reset
REQ-030 reset SHALL force state=IDLE, sda_oe=0, reg_ptr=8'h00, busy=0, xfer_done=0, hold=12'h000, synchronizers=1 (idle bus); reset mid-transfer SHALL release SDA on the next cycle.

Verification
REQ-031 angle=12'hABC; write 0x6C, 0x0C, Sr, 0x6D, read 2 bytes (ACK, NACK), P -> data 0x0A, 0xBC; reg_ptr=0x0E; one xfer_done pulse.
REQ-032 Write 0x6C, 0x0C; then angle changes from 12'h123 to 12'h456 between the two read bytes -> read returns 0x01, 0x23 (snapshot held).
REQ-033 Address 0x70 (0x38 write) -> no ACK, sda_oe stays 0, no xfer_done; a following transfer to 0x36 works.
REQ-034 reg_ptr=0xFF; read 2 bytes -> 0x00, 0x00; reg_ptr wraps to 0x01.
REQ-035 Read of 0x0B -> 0x20; a write of 3 data bytes after the pointer -> all ACKed, reg_ptr unchanged.
REQ-036 Assert reset while sda_oe=1 during a read -> sda_oe=0 next cycle, busy=0, reg_ptr=0x00.
